// File: rtl/spike_router_pipe_pkg.sv
// Shared encodings and saturation limits for the spike router pipeline.
package spike_router_pipe_pkg;

   typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_e;
   typedef enum logic {CLS_EX = 1'b0, CLS_IN = 1'b1} cls_e;

   localparam int unsigned SAT_MAX_W = 256;

   // Limits of a dw-bit two's complement value, held in the low dw bits.
   function automatic logic [SAT_MAX_W-1:0] sat_hi(input int unsigned dw);
      logic [SAT_MAX_W-1:0] v;
      v = '0;
      for (int unsigned i = 0; i + 1 < dw; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_lo(input int unsigned dw);
      logic [SAT_MAX_W-1:0] v;
      v = '0;
      v[dw-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/spike_router_pipe_if.sv
// Spike queue, synaptic RAM and dendritic RAM signals seen by the router.
interface spike_router_pipe_if #(
   parameter int NEURON_WIDTH = 14,
   parameter int ADDR_WIDTH   = 39,
   parameter int DATA_WIDTH   = 64
);
   logic                         SpikeValid;
   logic [NEURON_WIDTH-1:0]      SpikeID;
   logic                         SpikeReady;
   logic                         WChipEnable;
   logic [ADDR_WIDTH-1:0]        WRAMAddress;
   logic signed [DATA_WIDTH-1:0] WeightData;
   logic                         EXChipEnable;
   logic                         INChipEnable;
   logic [NEURON_WIDTH-1:0]      RdAddress;
   logic signed [DATA_WIDTH-1:0] ExWeightSum;
   logic signed [DATA_WIDTH-1:0] InWeightSum;
   logic                         EXWriteEnable;
   logic                         INWriteEnable;
   logic [NEURON_WIDTH-1:0]      WrAddress;
   logic signed [DATA_WIDTH-1:0] NewExWeightSum;
   logic signed [DATA_WIDTH-1:0] NewInWeightSum;

   modport master (
      input  SpikeValid, SpikeID, WeightData, ExWeightSum, InWeightSum,
      output SpikeReady, WChipEnable, WRAMAddress, EXChipEnable, INChipEnable, RdAddress,
             EXWriteEnable, INWriteEnable, WrAddress, NewExWeightSum, NewInWeightSum
   );

   modport slave (
      output SpikeValid, SpikeID, WeightData, ExWeightSum, InWeightSum,
      input  SpikeReady, WChipEnable, WRAMAddress, EXChipEnable, INChipEnable, RdAddress,
             EXWriteEnable, INWriteEnable, WrAddress, NewExWeightSum, NewInWeightSum
   );

endinterface

// File: rtl/spike_router_pipe_accumulate.sv
// Signed dendritic-sum adder; clamps to the type limits or wraps depending on SATURATE.
module weight_accumulate
   import spike_router_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter bit SATURATE   = 1'b0
)(
   input  logic signed [DATA_WIDTH-1:0] acc_in,
   input  logic signed [DATA_WIDTH-1:0] weight,
   output logic signed [DATA_WIDTH-1:0] sum
);

   localparam logic [DATA_WIDTH-1:0] POS_LIM = DATA_WIDTH'(sat_hi(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] NEG_LIM = DATA_WIDTH'(sat_lo(DATA_WIDTH));

   logic [DATA_WIDTH:0] wide;
   logic                ovf;

   // One guard bit: overflow shows up as guard and sign disagreeing.
   always_comb begin
      wide = {acc_in[DATA_WIDTH-1], acc_in} + {weight[DATA_WIDTH-1], weight};
      ovf  = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
      sum  = wide[DATA_WIDTH-1:0];
      if (SATURATE && ovf) sum = wide[DATA_WIDTH] ? NEG_LIM : POS_LIM;
   end

endmodule

// File: rtl/spike_router_pipe.sv
// Spike router: for each accepted spike, sweeps the logical neuron span one neuron
// per clock, reading synaptic weights and accumulating them into the dendritic sums.
module spike_router_pipe
   import spike_router_pipe_pkg::*;
#(
   parameter int INTEGER_WIDTH        = 32,
   parameter int DATA_WIDTH_FRAC      = 32,
   parameter int DATA_WIDTH           = INTEGER_WIDTH + DATA_WIDTH_FRAC,
   parameter int NEURON_WIDTH         = 14,
   parameter int NEURON_WIDTH_INPUT   = 11,
   parameter int ROW_WIDTH            = NEURON_WIDTH_INPUT + NEURON_WIDTH,
   parameter int ADDR_WIDTH           = ROW_WIDTH + NEURON_WIDTH,
   parameter int INPUT_NEURON_START   = 0,
   parameter int LOGICAL_NEURON_START = 2**NEURON_WIDTH_INPUT,
   parameter bit SATURATE             = 1'b0
)(
   input  logic                    Clock,
   input  logic                    ResetN,
   input  logic                    RouteEnable,
   input  logic                    Initialize,
   input  logic [NEURON_WIDTH-1:0] ExRangeLOWER,
   input  logic [NEURON_WIDTH-1:0] ExRangeUPPER,
   input  logic [NEURON_WIDTH-1:0] InRangeLOWER,
   input  logic [NEURON_WIDTH-1:0] InRangeUPPER,
   input  logic [NEURON_WIDTH-1:0] IPRangeLOWER,
   input  logic [NEURON_WIDTH-1:0] IPRangeUPPER,
   input  logic [NEURON_WIDTH-1:0] NeuStart,
   input  logic [NEURON_WIDTH-1:0] NeuEnd,
   output logic                    RoutingComplete,
   spike_router_pipe_if.master     bus
);

   typedef struct packed {
      logic                    vld;
      cls_e                    cls;
      logic [NEURON_WIDTH-1:0] addr;
   } wr_stage_t;

   typedef struct packed {
      logic                    vld;
      cls_e                    cls;
      logic [NEURON_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]   sum;
   } fwd_stage_t;

   state_e                  state_q, state_d;
   logic [NEURON_WIDTH-1:0] a_q, a_d;
   logic [NEURON_WIDTH-1:0] nid_q, nid_d;
   cls_e                    cls_q, cls_d;
   wr_stage_t               wr_q, wr_d;
   fwd_stage_t              fwd_q, fwd_d;
   logic                    run_q, run_d;

   logic [NEURON_WIDTH-1:0]      span;
   logic                         issue, last, spike_ready, accept, clr, fwd_hit;
   logic [ROW_WIDTH-1:0]         row;
   logic signed [DATA_WIDTH-1:0] read_sum, new_sum;
   logic                         in_range_unused;

   function automatic logic in_rng(input logic [NEURON_WIDTH-1:0] id, lo, hi);
      return (id >= lo) && (id <= hi);
   endfunction

   // The In class is everything outside Ex/IP, so its range only documents the map.
   assign in_range_unused = ^{InRangeLOWER, InRangeUPPER};

   assign span        = NeuEnd - NeuStart;
   assign issue       = (state_q == ST_SWEEP);
   assign last        = issue && (a_q == span);
   // run_q holds off the handshake until the first edge after reset release.
   assign spike_ready = run_q && RouteEnable && (!issue || last);
   assign accept      = bus.SpikeValid && spike_ready;
   assign clr         = (!RouteEnable && (issue || wr_q.vld)) || (Initialize && !RouteEnable);

   assign RoutingComplete = run_q && RouteEnable && !issue && !wr_q.vld && !bus.SpikeValid;

   always_comb begin
      if (in_rng(nid_q, IPRangeLOWER, IPRangeUPPER))
         row = ROW_WIDTH'(nid_q) + ROW_WIDTH'(INPUT_NEURON_START);
      else
         row = ROW_WIDTH'(nid_q) - ROW_WIDTH'(NeuStart) + ROW_WIDTH'(LOGICAL_NEURON_START);
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      nid_d      = nid_q;
      cls_d      = cls_q;
      run_d      = 1'b1;
      wr_d.vld   = issue;
      wr_d.cls   = cls_q;
      wr_d.addr  = a_q;
      fwd_d.vld  = wr_q.vld;
      fwd_d.cls  = wr_q.cls;
      fwd_d.addr = wr_q.addr;
      fwd_d.sum  = new_sum;
      if (accept) begin
         nid_d = bus.SpikeID;
         cls_d = (in_rng(bus.SpikeID, ExRangeLOWER, ExRangeUPPER) ||
                  in_rng(bus.SpikeID, IPRangeLOWER, IPRangeUPPER)) ? CLS_EX : CLS_IN;
      end
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SWEEP;
               a_d     = '0;
            end
         end
         ST_SWEEP: begin
            if (last) begin
               state_d = accept ? ST_SWEEP : ST_IDLE;
               a_d     = '0;
            end else begin
               a_d = a_q + NEURON_WIDTH'(1);
            end
         end
      endcase
      if (clr) begin
         state_d = ST_IDLE;
         a_d     = '0;
         wr_d    = '0;
         fwd_d   = '0;
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         nid_q   <= '0;
         cls_q   <= CLS_EX;
         wr_q    <= '0;
         fwd_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         nid_q   <= nid_d;
         cls_q   <= cls_d;
         wr_q    <= wr_d;
         fwd_q   <= fwd_d;
         run_q   <= run_d;
      end
   end

   // The RAM returns pre-write data when read and written together, so a
   // read that overlapped last cycle's write to the same word takes that sum.
   assign fwd_hit  = fwd_q.vld && wr_q.vld && (fwd_q.addr == wr_q.addr) && (fwd_q.cls == wr_q.cls);
   assign read_sum = fwd_hit ? fwd_q.sum
                             : ((wr_q.cls == CLS_EX) ? bus.ExWeightSum : bus.InWeightSum);

   weight_accumulate #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
   ) u_acc (
      .acc_in (read_sum),
      .weight (bus.WeightData),
      .sum    (new_sum)
   );

   assign bus.SpikeReady     = spike_ready;
   assign bus.WChipEnable    = issue;
   assign bus.WRAMAddress    = issue ? {row, a_q} : '0;
   assign bus.EXChipEnable   = issue && (cls_q == CLS_EX);
   assign bus.INChipEnable   = issue && (cls_q == CLS_IN);
   assign bus.RdAddress      = issue ? a_q : '0;
   assign bus.EXWriteEnable  = wr_q.vld && (wr_q.cls == CLS_EX);
   assign bus.INWriteEnable  = wr_q.vld && (wr_q.cls == CLS_IN);
   assign bus.WrAddress      = wr_q.vld ? wr_q.addr : '0;
   assign bus.NewExWeightSum = bus.EXWriteEnable ? new_sum : '0;
   assign bus.NewInWeightSum = bus.INWriteEnable ? new_sum : '0;

endmodule

// File: tb/tb_spike_router_pipe.sv
// Directed bench for spike_router_pipe: table vectors for row/class and the adder,
// hand sequences for sweep timing, forwarding, abort and asynchronous reset.
module tb_spike_router_pipe;
   import spike_router_pipe_pkg::*;

   localparam int NW = 14;
   localparam int DW = 64;
   localparam int RW = 25;
   localparam int AW = 39;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          route_en, init, routing_complete;
   logic [NW-1:0] ex_lo, ex_hi, in_lo, in_hi, ip_lo, ip_hi, neu_start, neu_end;

   spike_router_pipe_if #(.NEURON_WIDTH(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   spike_router_pipe dut (
      .Clock           (clk),
      .ResetN          (rst_n),
      .RouteEnable     (route_en),
      .Initialize      (init),
      .ExRangeLOWER    (ex_lo),
      .ExRangeUPPER    (ex_hi),
      .InRangeLOWER    (in_lo),
      .InRangeUPPER    (in_hi),
      .IPRangeLOWER    (ip_lo),
      .IPRangeUPPER    (ip_hi),
      .NeuStart        (neu_start),
      .NeuEnd          (neu_end),
      .RoutingComplete (routing_complete),
      .bus             (bus)
   );

   logic signed [7:0] add_a, add_b, sat_sum, wrap_sum;
   weight_accumulate #(.DATA_WIDTH(8), .SATURATE(1'b1)) u_sat  (.acc_in(add_a), .weight(add_b), .sum(sat_sum));
   weight_accumulate #(.DATA_WIDTH(8), .SATURATE(1'b0)) u_wrap (.acc_in(add_a), .weight(add_b), .sum(wrap_sum));

   // Synaptic and dendritic RAM models: one-cycle read, read-before-write.
   logic signed [DW-1:0] wmem [16];
   logic signed [DW-1:0] ex_mem [16] = '{default: '0};
   logic signed [DW-1:0] in_mem [16] = '{default: '0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.WeightData  <= '0;
         bus.ExWeightSum <= '0;
         bus.InWeightSum <= '0;
      end else begin
         if (bus.WChipEnable)   bus.WeightData  <= wmem[bus.WRAMAddress[3:0]];
         if (bus.EXChipEnable)  bus.ExWeightSum <= ex_mem[bus.RdAddress[3:0]];
         if (bus.INChipEnable)  bus.InWeightSum <= in_mem[bus.RdAddress[3:0]];
         if (bus.EXWriteEnable) ex_mem[bus.WrAddress[3:0]] <= bus.NewExWeightSum;
         if (bus.INWriteEnable) in_mem[bus.WrAddress[3:0]] <= bus.NewInWeightSum;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_spike(input logic [NW-1:0] id);
      @(posedge clk); #1;
      bus.SpikeValid = 1'b1;
      bus.SpikeID    = id;
      @(posedge clk); #1;
      bus.SpikeValid = 1'b0;
   endtask

   typedef struct {
      logic [NW-1:0] id;
      logic [NW-1:0] start;
      int            row;
      logic          cls;
   } rvec_t;

   typedef struct {
      int a;
      int b;
      int sat;
      int wrap;
   } avec_t;

   rvec_t rv [8];
   avec_t av [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] e8;
      logic [5:0] en_bits;

      rv[0] = '{id: 14'd3,    start: 14'd2048, row: 3,    cls: 1'b0};
      rv[1] = '{id: 14'd2100, start: 14'd2048, row: 2100, cls: 1'b1};
      rv[2] = '{id: 14'd25,   start: 14'd20,   row: 2053, cls: 1'b0};
      rv[3] = '{id: 14'd10,   start: 14'd0,    row: 10,   cls: 1'b0};
      rv[4] = '{id: 14'd11,   start: 14'd0,    row: 2059, cls: 1'b1};
      rv[5] = '{id: 14'd20,   start: 14'd20,   row: 2048, cls: 1'b0};
      rv[6] = '{id: 14'd30,   start: 14'd0,    row: 2078, cls: 1'b0};
      rv[7] = '{id: 14'd31,   start: 14'd0,    row: 2079, cls: 1'b1};

      av[0] = '{a: 120,  b: 20,  sat: 127,  wrap: -116};
      av[1] = '{a: -120, b: -20, sat: -128, wrap: 116};
      av[2] = '{a: 100,  b: 27,  sat: 127,  wrap: 127};
      av[3] = '{a: -100, b: -28, sat: -128, wrap: -128};
      av[4] = '{a: 50,   b: -70, sat: -20,  wrap: -20};
      av[5] = '{a: 127,  b: 1,   sat: 127,  wrap: -128};
      av[6] = '{a: -128, b: -1,  sat: -128, wrap: 127};

      route_en = 1'b1; init = 1'b0;
      bus.SpikeValid = 1'b0; bus.SpikeID = '0;
      ex_lo = 0;   ex_hi = 15; in_lo = 16; in_hi = 99;
      ip_lo = 100; ip_hi = 110; neu_start = 0; neu_end = 3;
      add_a = '0; add_b = '0;
      for (int i = 0; i < 16; i++) wmem[i] = DW'(i + 1);

      // Reset state, RouteEnable already high
      #1 rst_n = 1'b0;
      #2;
      check("rst_ready", 64'(bus.SpikeReady), 64'd0);
      check("rst_complete", 64'(routing_complete), 64'd0);
      check("rst_wce", 64'(bus.WChipEnable), 64'd0);
      check("rst_waddr", 64'(bus.WRAMAddress), 64'd0);
      #10 rst_n = 1'b1;
      #1;
      check("post_rel_ready", 64'(bus.SpikeReady), 64'd0);
      @(posedge clk); #1;
      check("first_edge_ready", 64'(bus.SpikeReady), 64'd1);
      check("idle_complete", 64'(routing_complete), 64'd1);

      // Ex spike over span 0..3 with weights 1..4
      bus.SpikeValid = 1'b1; bus.SpikeID = 14'd5;
      @(negedge clk);
      check("valid_blocks_complete", 64'(routing_complete), 64'd0);
      @(posedge clk); #1 bus.SpikeValid = 1'b0;
      @(negedge clk);
      check("sweep_wce", 64'(bus.WChipEnable), 64'd1);
      check("sweep_ce", 64'({bus.EXChipEnable, bus.INChipEnable}), 64'b10);
      check("sweep_waddr", 64'(bus.WRAMAddress), 64'({RW'(2053), NW'(0)}));
      check("sweep_ready", 64'(bus.SpikeReady), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("ex_we", 64'({bus.EXWriteEnable, bus.INWriteEnable}), 64'b10);
         check("ex_wraddr", 64'(bus.WrAddress), 64'(k));
         check("ex_sum", 64'(bus.NewExWeightSum), 64'(k + 1));
         check("in_sum_zero", 64'(bus.NewInWeightSum), 64'd0);
      end
      @(negedge clk);
      check("done_complete", 64'(routing_complete), 64'd1);
      check("done_we", 64'(bus.EXWriteEnable), 64'd0);

      // Span 0, two back-to-back In spikes, second sum forwarded
      neu_start = 40; neu_end = 40; wmem[0] = 7;
      @(posedge clk); #1;
      bus.SpikeValid = 1'b1; bus.SpikeID = 14'd40;
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b_ince", 64'(bus.INChipEnable), 64'd1);
      check("b2b_ready_last", 64'(bus.SpikeReady), 64'd1);
      @(posedge clk); #1 bus.SpikeValid = 1'b0;
      @(negedge clk);
      check("b2b_first_we", 64'({bus.EXWriteEnable, bus.INWriteEnable}), 64'b01);
      check("b2b_first_sum", 64'(bus.NewInWeightSum), 64'd7);
      check("b2b_ex_zero", 64'(bus.NewExWeightSum), 64'd0);
      @(negedge clk);
      check("b2b_fwd_sum", 64'(bus.NewInWeightSum), 64'd14);
      @(negedge clk);
      check("b2b_complete", 64'(routing_complete), 64'd1);

      // Row and class table, span 0
      ex_lo = 20; ex_hi = 30; ip_lo = 0; ip_hi = 10;
      for (int i = 0; i < 8; i++) begin
         neu_start = rv[i].start; neu_end = rv[i].start;
         send_spike(rv[i].id);
         @(negedge clk);
         check("tbl_row", 64'(bus.WRAMAddress[AW-1:NW]), 64'(rv[i].row));
         check("tbl_col", 64'(bus.WRAMAddress[NW-1:0]), 64'd0);
         check("tbl_ce", 64'({bus.EXChipEnable, bus.INChipEnable}), rv[i].cls ? 64'b01 : 64'b10);
         repeat (3) @(posedge clk);
      end

      // Adder limits at 8 bits
      for (int i = 0; i < 7; i++) begin
         add_a = 8'(av[i].a); add_b = 8'(av[i].b);
         #1;
         e8 = 8'(av[i].sat);
         check("add_sat", 64'(unsigned'(sat_sum)), 64'(e8));
         e8 = 8'(av[i].wrap);
         check("add_wrap", 64'(unsigned'(wrap_sum)), 64'(e8));
      end

      // RouteEnable dropped at A=2 of span 5
      ex_lo = 0; ex_hi = 15; ip_lo = 100; ip_hi = 110;
      neu_start = 0; neu_end = 5;
      send_spike(14'd5);
      @(posedge clk);
      @(posedge clk); #1 route_en = 1'b0;
      @(negedge clk);
      check("abort_at_a2", 64'(bus.RdAddress), 64'd2);
      check("abort_wr_a1", 64'(bus.WrAddress), 64'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         en_bits = {bus.WChipEnable, bus.EXChipEnable, bus.INChipEnable,
                    bus.EXWriteEnable, bus.INWriteEnable, bus.SpikeReady};
         check("abort_enables", 64'(en_bits), 64'd0);
         check("abort_rdaddr", 64'(bus.RdAddress), 64'd0);
      end
      @(posedge clk); #1 route_en = 1'b1;
      @(negedge clk);
      check("abort_recover", 64'(routing_complete), 64'd1);

      // Initialize is ignored while routing
      neu_end = 3;
      send_spike(14'd5);
      @(posedge clk); #1 init = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("init_ign_we", 64'(bus.EXWriteEnable), 64'd1);
      check("init_ign_addr", 64'(bus.WrAddress), 64'd3);
      @(posedge clk); #1 init = 1'b0;
      @(negedge clk);
      check("init_ign_done", 64'(routing_complete), 64'd1);

      // Asynchronous reset mid-sweep
      neu_end = 5;
      send_spike(14'd5);
      @(posedge clk);
      @(posedge clk); #1;
      check("pre_rst_we", 64'({bus.WChipEnable, bus.EXWriteEnable}), 64'b11);
      rst_n = 1'b0;
      #1;
      en_bits = {bus.WChipEnable, bus.EXChipEnable, bus.INChipEnable,
                 bus.EXWriteEnable, bus.INWriteEnable, bus.SpikeReady};
      check("arst_enables", 64'(en_bits), 64'd0);
      check("arst_complete", 64'(routing_complete), 64'd0);
      check("arst_waddr", 64'(bus.WRAMAddress), 64'd0);
      check("arst_addrs", 64'({bus.RdAddress, bus.WrAddress}), 64'd0);
      check("arst_sums", 64'(bus.NewExWeightSum | bus.NewInWeightSum), 64'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      check("arst_rel_ready", 64'(bus.SpikeReady), 64'd0);
      @(posedge clk); #1;
      check("arst_edge_ready", 64'(bus.SpikeReady), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
